// File: rtl/y86_pkg.sv
// Shared Y86-64 constants and the D-register record used by the fetch pipe.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
  } d_reg_t;

  localparam d_reg_t D_BUBBLE = '{stat: S_AOK, icode: I_NOP, ifun: 4'h0,
                                  rA: RNONE, rB: RNONE, valC: 64'd0, valP: 64'd0};

  function automatic logic need_regids(input logic [3:0] ic);
    return ic inside {I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ};
  endfunction

  function automatic logic need_valc(input logic [3:0] ic);
    return ic inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL};
  endfunction

endpackage

// File: rtl/y86_fetch_pipe_if.sv
// Program-load byte-write bus into the fetch stage's instruction memory.
interface y86_fetch_pipe_if;
  logic        imem_we;
  logic [63:0] imem_waddr;
  logic [7:0]  imem_wdata;

  modport master (output imem_we, imem_waddr, imem_wdata);
  modport slave  (input  imem_we, imem_waddr, imem_wdata);
endinterface

// File: rtl/y86_fetch_decode.sv
// Combinational decode of the up-to-10 instruction bytes starting at the fetch PC.
module y86_fetch_decode
  import y86_pkg::*;
#(
  parameter int IMEM_BYTES = 1024
) (
  input  logic [63:0]     pc_i,
  input  logic [9:0][7:0] bytes_i,    // bytes_i[k] = imem[pc_i + k], 0 when out of range
  output d_reg_t          f_o,
  output logic [63:0]     pred_pc_o
);

  localparam logic [63:0] MEM_TOP = 64'(IMEM_BYTES);

  logic [3:0]  icode_raw;
  logic        nr, nv, err, valid;
  logic [63:0] len;

  // Field extraction, instruction length, bounds check and status.
  always_comb begin
    f_o       = D_BUBBLE;
    icode_raw = bytes_i[0][7:4];
    nr        = need_regids(icode_raw);
    nv        = need_valc(icode_raw);
    len       = 64'd1 + {63'd0, nr} + (nv ? 64'd8 : 64'd0);
    // pc >= top checked first so the subtraction below never underflows
    err       = (pc_i >= MEM_TOP) || (len > (MEM_TOP - pc_i));
    valid     = (icode_raw <= I_POPQ);

    f_o.icode = err ? I_NOP : icode_raw;
    f_o.ifun  = err ? 4'h0  : bytes_i[0][3:0];
    f_o.rA    = nr ? bytes_i[1][7:4] : RNONE;
    f_o.rB    = nr ? bytes_i[1][3:0] : RNONE;
    f_o.valC  = 64'd0;
    if (nv) begin
      for (int k = 0; k < 8; k++)
        f_o.valC[8*k +: 8] = nr ? bytes_i[k+2] : bytes_i[k+1];
    end
    f_o.valP  = pc_i + len;

    if (err)              f_o.stat = S_ADR;
    else if (!valid)      f_o.stat = S_INS;
    else if (icode_raw == I_HALT) f_o.stat = S_HLT;
    else                  f_o.stat = S_AOK;

    pred_pc_o = (f_o.icode == I_JXX || f_o.icode == I_CALL) ? f_o.valC : f_o.valP;
  end

endmodule

// File: rtl/y86_fetch_pipe.sv
// Pipelined Y86-64 fetch: PC select, F register, instruction memory, D register, sticky halt.
module y86_fetch_pipe
  import y86_pkg::*;
#(
  parameter int          IMEM_BYTES = 1024,
  parameter logic [63:0] RESET_PC   = 64'h0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        f_stall_i,
  input  logic        d_stall_i,
  input  logic        d_bubble_i,
  input  logic [3:0]  m_icode_i,
  input  logic        m_cnd_i,
  input  logic [63:0] m_valA_i,
  input  logic [3:0]  w_icode_i,
  input  logic [63:0] w_valM_i,
  y86_fetch_pipe_if.slave imem_if,
  output logic [63:0] f_pc_o,
  output logic [63:0] f_predPC_o,
  output logic [2:0]  D_stat_o,
  output logic [3:0]  D_icode_o,
  output logic [3:0]  D_ifun_o,
  output logic [3:0]  D_rA_o,
  output logic [3:0]  D_rB_o,
  output logic [63:0] D_valC_o,
  output logic [63:0] D_valP_o
);

  localparam int          AW      = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
  localparam logic [63:0] MEM_TOP = 64'(IMEM_BYTES);

  logic [7:0]       mem_q [IMEM_BYTES];
  logic [63:0]      predpc_q, predpc_d, pred_next, f_pc;
  d_reg_t           d_q, d_d, f_dec;
  logic             halt_q, halt_d;
  logic             mispred, ret_sel, redirect, halt_eff, load_fetch;
  logic [9:0][63:0] rd_addr;
  logic [9:0][7:0]  rd_bytes;

  // Program-load port; out-of-range writes are dropped. Contents survive reset.
  always_ff @(posedge clk_i) begin
    if (imem_if.imem_we && (imem_if.imem_waddr < MEM_TOP))
      mem_q[imem_if.imem_waddr[AW-1:0]] <= imem_if.imem_wdata;
  end

  // PC select: mispredict correction beats ret, ret beats prediction.
  always_comb begin
    mispred  = (m_icode_i == I_JXX) && !m_cnd_i;
    ret_sel  = (w_icode_i == I_RET);
    redirect = mispred || ret_sel;
    f_pc     = mispred ? m_valA_i : (ret_sel ? w_valM_i : predpc_q);
  end

  // Combinational read of the 10-byte window; bytes past the end read as zero.
  always_comb begin
    rd_addr  = '0;
    rd_bytes = '0;
    for (int k = 0; k < 10; k++) begin
      rd_addr[k] = f_pc + 64'(k);
      if (rd_addr[k] < MEM_TOP) rd_bytes[k] = mem_q[rd_addr[k][AW-1:0]];
    end
  end

  y86_fetch_decode #(.IMEM_BYTES(IMEM_BYTES)) u_dec (
    .pc_i      (f_pc),
    .bytes_i   (rd_bytes),
    .f_o       (f_dec),
    .pred_pc_o (pred_next)
  );

  // Next-state for F, D and halt; a redirect overrides a pending halt this cycle.
  always_comb begin
    halt_eff   = halt_q && !redirect;
    predpc_d   = (f_stall_i || halt_eff) ? predpc_q : pred_next;
    load_fetch = !d_stall_i && !d_bubble_i && !halt_eff;
    if (d_stall_i)                   d_d = d_q;
    else if (d_bubble_i || halt_eff) d_d = D_BUBBLE;
    else                             d_d = f_dec;
    if (load_fetch && (f_dec.stat != S_AOK)) halt_d = 1'b1;
    else if (redirect)                       halt_d = 1'b0;
    else                                     halt_d = halt_q;
  end

  // Pipeline registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      predpc_q <= RESET_PC;
      d_q      <= D_BUBBLE;
      halt_q   <= 1'b0;
    end else begin
      predpc_q <= predpc_d;
      d_q      <= d_d;
      halt_q   <= halt_d;
    end
  end

  assign f_pc_o     = f_pc;
  assign f_predPC_o = predpc_q;
  assign D_stat_o   = d_q.stat;
  assign D_icode_o  = d_q.icode;
  assign D_ifun_o   = d_q.ifun;
  assign D_rA_o     = d_q.rA;
  assign D_rB_o     = d_q.rB;
  assign D_valC_o   = d_q.valC;
  assign D_valP_o   = d_q.valP;

endmodule

// File: tb/tb_y86_fetch_pipe.sv
// Bench for y86_fetch_pipe: directed scenarios plus a random stream against a behavioural model.
module tb_y86_fetch_pipe;

  localparam int          IMEM = 256;
  localparam logic [63:0] RPC  = 64'h0;
  localparam logic [146:0] BUB = {3'd1, 4'd1, 4'd0, 4'hF, 4'hF, 64'd0, 64'd0};

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        f_stall = 0, d_stall = 0, d_bubble = 0, m_cnd = 0;
  logic [3:0]  m_icode = 0, w_icode = 0;
  logic [63:0] m_valA = 0, w_valM = 0;
  logic [63:0] f_pc_o, f_predPC_o, D_valC_o, D_valP_o;
  logic [2:0]  D_stat_o;
  logic [3:0]  D_icode_o, D_ifun_o, D_rA_o, D_rB_o;

  y86_fetch_pipe_if imem_if ();

  y86_fetch_pipe #(.IMEM_BYTES(IMEM), .RESET_PC(RPC)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .f_stall_i(f_stall), .d_stall_i(d_stall),
    .d_bubble_i(d_bubble), .m_icode_i(m_icode), .m_cnd_i(m_cnd), .m_valA_i(m_valA),
    .w_icode_i(w_icode), .w_valM_i(w_valM), .imem_if(imem_if),
    .f_pc_o(f_pc_o), .f_predPC_o(f_predPC_o), .D_stat_o(D_stat_o), .D_icode_o(D_icode_o),
    .D_ifun_o(D_ifun_o), .D_rA_o(D_rA_o), .D_rB_o(D_rB_o), .D_valC_o(D_valC_o),
    .D_valP_o(D_valP_o)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0]  stat;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP, nxt;
  } fx_t;

  logic [7:0]  mm [IMEM];
  logic [63:0] m_pred = RPC;
  fx_t         m_d;
  bit          m_halt = 0;

  function automatic logic [7:0] rd(input logic [63:0] a);
    return (a < 64'(IMEM)) ? mm[int'(a)] : 8'h00;
  endfunction

  function automatic fx_t bubble();
    fx_t b;
    b.stat = 1; b.icode = 1; b.ifun = 0; b.rA = 4'hF; b.rB = 4'hF;
    b.valC = 0; b.valP = 0; b.nxt = 0;
    return b;
  endfunction

  function automatic logic [146:0] pack(input fx_t f);
    return {f.stat, f.icode, f.ifun, f.rA, f.rB, f.valC, f.valP};
  endfunction

  // One instruction fetched at pc, from the instruction-set rules.
  function automatic fx_t fetch(input logic [63:0] pc);
    fx_t f;
    logic [7:0] b0;
    int nr, nv;
    logic [63:0] len;
    bit err;
    b0 = rd(pc);
    nr = (b0[7:4] inside {2, 3, 4, 5, 6, 10, 11}) ? 1 : 0;
    nv = (b0[7:4] inside {3, 4, 5, 7, 8}) ? 1 : 0;
    len = 64'(1 + nr + 8 * nv);
    err = (pc >= 64'(IMEM)) || ((64'(IMEM) - pc) < len);
    f.icode = err ? 4'd1 : b0[7:4];
    f.ifun  = err ? 4'd0 : b0[3:0];
    f.rA = nr ? rd(pc + 1) >> 4 : 4'hF;
    f.rB = nr ? rd(pc + 1) & 8'h0F : 4'hF;
    f.valC = 0;
    if (nv)
      for (int k = 7; k >= 0; k--) f.valC = (f.valC << 8) | 64'(rd(pc + 64'(1 + nr + k)));
    f.valP = pc + len;
    if (err) f.stat = 3;
    else if (b0[7:4] > 4'hB) f.stat = 4;
    else if (b0[7:4] == 0) f.stat = 2;
    else f.stat = 1;
    f.nxt = (f.icode == 7 || f.icode == 8) ? f.valC : f.valP;
    return f;
  endfunction

  function automatic logic [63:0] model_pc();
    if (m_icode == 7 && !m_cnd) return m_valA;
    if (w_icode == 9) return w_valM;
    return m_pred;
  endfunction

  // Advance one clock: DUT and model together; samples land 1 time unit after the edge.
  task automatic step();
    fx_t f, nd;
    bit redir, halted, nh;
    logic [63:0] np;
    bit wr;
    logic [63:0] wa;
    logic [7:0] wd;
    redir  = (m_icode == 7 && !m_cnd) || (w_icode == 9);
    halted = m_halt && !redir;
    f      = fetch(model_pc());
    np     = (f_stall || halted) ? m_pred : f.nxt;
    if (d_stall) nd = m_d;
    else if (d_bubble || halted) nd = bubble();
    else nd = f;
    if (!d_stall && !d_bubble && !halted && f.stat != 1) nh = 1;
    else if (redir) nh = 0;
    else nh = m_halt;
    wr = imem_if.imem_we && (imem_if.imem_waddr < 64'(IMEM));
    wa = imem_if.imem_waddr; wd = imem_if.imem_wdata;
    @(posedge clk); #1;
    if (wr) mm[int'(wa)] = wd;
    if (!rst_n) begin
      m_pred = RPC; m_d = bubble(); m_halt = 0;
    end else begin
      m_pred = np; m_d = nd; m_halt = nh;
    end
  endtask

  task automatic load_byte(input logic [63:0] a, input logic [7:0] d);
    imem_if.imem_we = 1; imem_if.imem_waddr = a; imem_if.imem_wdata = d;
    step();
    imem_if.imem_we = 0;
  endtask

  task automatic clear_ctl();
    f_stall = 0; d_stall = 0; d_bubble = 0; m_icode = 0; m_cnd = 0; m_valA = 0;
    w_icode = 0; w_valM = 0;
  endtask

  task automatic enter_reset();
    rst_n = 0; clear_ctl(); step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    enter_reset();
    for (int a = 0; a < IMEM; a++) load_byte(64'(a), 8'h00);
    total++; if (f_predPC_o !== RPC) begin bad++; $display("FAIL reset_predpc got=%h exp=%h", f_predPC_o, RPC); end
    total++;
    if ({D_stat_o, D_icode_o, D_ifun_o, D_rA_o, D_rB_o, D_valC_o, D_valP_o} !== BUB) begin
      bad++; $display("FAIL reset_d got stat=%0d icode=%h valP=%h", D_stat_o, D_icode_o, D_valP_o);
    end
  endtask

  task automatic test_irmovq_halt();
    logic [7:0] prog [11] = '{8'h30, 8'hF5, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'h00};
    enter_reset();
    for (int i = 0; i < 11; i++) load_byte(64'(i), prog[i]);
    rst_n = 1; #1;
    total++; if (f_pc_o !== 64'h0) begin bad++; $display("FAIL first_fpc got=%h exp=0", f_pc_o); end
    step();
    total++;
    if ({D_stat_o, D_icode_o, D_rA_o, D_rB_o, D_valC_o, D_valP_o} !==
        {3'd1, 4'h3, 4'hF, 4'h5, 64'h0123456789ABCDEF, 64'h0A}) begin
      bad++; $display("FAIL irmovq_d got icode=%h rA=%h rB=%h valC=%h valP=%h",
                      D_icode_o, D_rA_o, D_rB_o, D_valC_o, D_valP_o);
    end
    step();
    total++; if (D_stat_o !== 3'd2 || D_valP_o !== 64'h0B) begin
      bad++; $display("FAIL halt_stat got stat=%0d valP=%h exp stat=2 valP=0b", D_stat_o, D_valP_o);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if (f_predPC_o !== 64'h0B ||
          {D_stat_o, D_icode_o, D_ifun_o, D_rA_o, D_rB_o, D_valC_o, D_valP_o} !== BUB) begin
        bad++; $display("FAIL halt_hold c=%0d got predPC=%h icode=%h valP=%h", c, f_predPC_o, D_icode_o, D_valP_o);
      end
    end
  endtask

  task automatic test_jxx_mispredict();
    enter_reset();
    load_byte(0, 8'h70); load_byte(1, 8'h20);
    for (int i = 2; i < 9; i++) load_byte(64'(i), 8'h00);
    load_byte(9, 8'h10); load_byte(64'h20, 8'h10);
    rst_n = 1; step();
    total++; if (D_icode_o !== 4'h7 || D_valC_o !== 64'h20 || f_predPC_o !== 64'h20) begin
      bad++; $display("FAIL jxx_pred got icode=%h valC=%h predPC=%h", D_icode_o, D_valC_o, f_predPC_o);
    end
    m_icode = 7; m_cnd = 0; m_valA = 64'h09; w_icode = 9; w_valM = 64'h20; #1;
    total++; if (f_pc_o !== 64'h09) begin bad++; $display("FAIL mispred_prio got=%h exp=09", f_pc_o); end
    w_icode = 0; #1;
    total++; if (f_pc_o !== 64'h09) begin bad++; $display("FAIL mispred_fpc got=%h exp=09", f_pc_o); end
    step(); clear_ctl();
    total++; if (D_icode_o !== 4'h1 || D_valP_o !== 64'h0A || f_predPC_o !== 64'h0A) begin
      bad++; $display("FAIL mispred_resume got icode=%h valP=%h predPC=%h", D_icode_o, D_valP_o, f_predPC_o);
    end
    w_icode = 9; w_valM = 64'h20; #1;
    total++; if (f_pc_o !== 64'h20) begin bad++; $display("FAIL ret_fpc got=%h exp=20", f_pc_o); end
    clear_ctl();
  endtask

  task automatic test_ins_adr();
    enter_reset();
    load_byte(0, 8'h70); load_byte(1, 8'h10);
    for (int i = 2; i < 9; i++) load_byte(64'(i), 8'h00);
    load_byte(64'h10, 8'hE0);
    rst_n = 1; step(); step();
    total++; if (D_stat_o !== 3'd4) begin bad++; $display("FAIL ins_stat got=%0d exp=4", D_stat_o); end
    enter_reset();
    load_byte(1, 8'h00 + 8'(IMEM - 2));
    load_byte(64'(IMEM - 2), 8'h30);
    rst_n = 1; step(); step();
    total++; if (D_stat_o !== 3'd3 || D_icode_o !== 4'h1 || D_ifun_o !== 4'h0) begin
      bad++; $display("FAIL adr_d got stat=%0d icode=%h ifun=%h exp 3/1/0", D_stat_o, D_icode_o, D_ifun_o);
    end
  endtask

  task automatic test_stall_bubble();
    enter_reset();
    for (int i = 0; i < 16; i++) load_byte(64'(i), 8'h10);
    rst_n = 1; step(); step();
    f_stall = 1; d_stall = 1;
    for (int c = 0; c < 3; c++) begin
      m_icode = 7; m_cnd = 0; m_valA = 64'h30; #1;
      total++; if (f_pc_o !== 64'h30) begin bad++; $display("FAIL stall_redirect_fpc got=%h exp=30", f_pc_o); end
      clear_ctl(); f_stall = 1; d_stall = 1;
      step();
      total++; if (f_predPC_o !== 64'h2 || D_valP_o !== 64'h2) begin
        bad++; $display("FAIL stall_hold c=%0d got predPC=%h valP=%h exp 2/2", c, f_predPC_o, D_valP_o);
      end
    end
    clear_ctl(); d_bubble = 1; step();
    total++;
    if ({D_stat_o, D_icode_o, D_ifun_o, D_rA_o, D_rB_o, D_valC_o, D_valP_o} !== BUB || f_predPC_o !== 64'h3) begin
      bad++; $display("FAIL bubble got valP=%h predPC=%h", D_valP_o, f_predPC_o);
    end
    d_bubble = 0; step();
    d_stall = 1; d_bubble = 1; step();
    total++; if (D_valP_o !== 64'h4 || D_icode_o !== 4'h1 || f_predPC_o !== 64'h5) begin
      bad++; $display("FAIL stall_over_bubble got valP=%h predPC=%h exp 4/5", D_valP_o, f_predPC_o);
    end
    clear_ctl();
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic [63:0] epc;
    enter_reset();
    for (int a = 0; a < IMEM; a++) begin
      b[7:4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 11));
      b[3:0] = 4'($urandom_range(0, 15));
      load_byte(64'(a), b);
    end
    rst_n = 1;
    for (int c = 0; c < 400; c++) begin
      f_stall  = ($urandom_range(0, 99) < 15);
      d_stall  = ($urandom_range(0, 99) < 15);
      d_bubble = ($urandom_range(0, 99) < 10);
      m_icode  = ($urandom_range(0, 99) < 15) ? 4'h7 : 4'($urandom_range(0, 6));
      m_cnd    = 1'($urandom_range(0, 1));
      m_valA   = 64'($urandom_range(0, IMEM - 1));
      w_icode  = ($urandom_range(0, 99) < 10) ? 4'h9 : 4'($urandom_range(0, 8));
      w_valM   = 64'($urandom_range(0, IMEM - 1));
      #1;
      epc = model_pc();
      total++; if (f_pc_o !== epc) begin bad++; $display("FAIL rnd_fpc c=%0d got=%h exp=%h", c, f_pc_o, epc); end
      step();
      total++; if (f_predPC_o !== m_pred) begin bad++; $display("FAIL rnd_predpc c=%0d got=%h exp=%h", c, f_predPC_o, m_pred); end
      total++;
      if ({D_stat_o, D_icode_o, D_ifun_o, D_rA_o, D_rB_o, D_valC_o, D_valP_o} !== pack(m_d)) begin
        bad++; $display("FAIL rnd_d c=%0d got=%h exp=%h", c,
                        {D_stat_o, D_icode_o, D_ifun_o, D_rA_o, D_rB_o, D_valC_o, D_valP_o}, pack(m_d));
      end
    end
    clear_ctl();
  endtask

  task automatic test_async_reset();
    fx_t f0;
    step();
    rst_n = 0; #2;
    m_pred = RPC; m_d = bubble(); m_halt = 0;
    total++; if (f_predPC_o !== RPC) begin bad++; $display("FAIL async_predpc got=%h exp=%h", f_predPC_o, RPC); end
    total++;
    if ({D_stat_o, D_icode_o, D_ifun_o, D_rA_o, D_rB_o, D_valC_o, D_valP_o} !== BUB) begin
      bad++; $display("FAIL async_d got stat=%0d icode=%h valP=%h", D_stat_o, D_icode_o, D_valP_o);
    end
    step();
    rst_n = 1; #1;
    f0 = fetch(RPC);
    step();
    total++;
    if ({D_stat_o, D_icode_o, D_ifun_o, D_rA_o, D_rB_o, D_valC_o, D_valP_o} !== pack(f0)) begin
      bad++; $display("FAIL post_reset_d got=%h exp=%h",
                      {D_stat_o, D_icode_o, D_ifun_o, D_rA_o, D_rB_o, D_valC_o, D_valP_o}, pack(f0));
    end
  endtask

  initial begin
    imem_if.imem_we = 0; imem_if.imem_waddr = 0; imem_if.imem_wdata = 0;
    m_d = bubble();
    test_reset();
    test_irmovq_halt();
    test_jxx_mispredict();
    test_ins_adr();
    test_stall_bubble();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
